rmap_reply_tx: RTL
==================

# rmap_reply_tx

Reply-packet transmitter for the RMAP target. It takes one reply request from the command decoder or transaction controller, serialises the complete RMAP reply into the SpaceWire TX FIFO, and terminates it with EOP. The packet contains reply address, header, header CRC, optional read data with data CRC, then EOP. It sits between the target's control logic and the 9-bit TX FIFO (flag + byte), and is the outbound counterpart of the RX command path.

## Interface
- REPLY_ADDR_BYTES, 12: width in bytes of the reply-address input; maximum 12 per RMAP.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- replyStart  in  1  request pulse; accepted only when busy=0, ignored otherwise.
- replyInstr  in  8  instruction byte of the originating command.
- replyStatus  in  8  RMAP status/error code.
- replyInitLA  in  8  initiator logical address.
- replyTargLA  in  8  target logical address.
- replyTransID  in  16  transaction ID.
- replyDataLen  in  24  read data length in bytes; read replies only.
- replyAddr  in  8*REPLY_ADDR_BYTES  reply address; byte 0 in the MSBs.
- busy  out  1  request latched, packet in progress.
- replyDone  out  1  one-cycle pulse after EOP/EEP is written.
- rdData  in  8  read-data byte from the bus side.
- rdValid  in  1  rdData valid.
- rdReady  out  1  byte taken this cycle; a transfer occurs when rdValid & rdReady.
- rdError  in  1  data source failed; abort the packet.
- txWriteEnable  out  1  TX FIFO write strobe.
- txDataIn  out  9  {flag, byte}; EOP = 9'h100, EEP = 9'h101.
- txFull  in  1  TX FIFO full.

## Operation
- On replyStart with busy=0, latch all reply* inputs and go to ADDR. All inputs are don't-care afterwards.
- Reply instruction = {2'b00, replyInstr[5:0]}. Write reply when replyInstr[5]=1, else read reply (read and RMW).
- Reply address byte count = replyInstr[1:0]*4. Leading 0x00 bytes are skipped; if all are zero, none are sent. Count 0 skips ADDR.
- Write-reply header: InitLA, 0x01, instr, status, TargLA, TID[15:8], TID[7:0], then header CRC, then EOP.
- Read-reply header: InitLA, 0x01, instr, status, TargLA, TID[15:8], TID[7:0], 0x00, Len[23:16], Len[15:8], Len[7:0], then header CRC, DATA, data CRC, EOP.
- When replyStatus≠0 on a read reply: the length field is sent as 0, DATA is skipped, and the data CRC is 0x00.
- CRC: RMAP CRC-8 (x^8+x^2+x+1), init 0x00, reflected, bit-serial equivalent `crc^=b; 8×{crc = crc[0] ? (crc>>1)^8'hE0 : crc>>1}`. One byte per cycle.
  - The header CRC covers InitLA through the last header byte; reply-address bytes are excluded.
  - The data CRC covers the data bytes only.
- States: IDLE → ADDR → HDR → HCRC → (write: EOP | read: DATA → DCRC → EOP) → IDLE.
  - DATA length 0 goes straight to DCRC.
  - rdError sampled high in DATA → EEP → IDLE. No data CRC is sent.
  - rdError outside DATA is ignored.
- Data counter is 24-bit; it decrements per accepted byte, and DATA exits when it reaches 0.

## Timing
- Reset values: busy=0, replyDone=0, rdReady=0, txWriteEnable=0, txDataIn=9'h000, state IDLE, CRC=0.
- txWriteEnable = (char pending) & !txFull, combinational on txFull. It is never high while txFull=1, and at most one char is written per cycle.
- txDataIn is driven combinationally with the strobe. It holds the pending char while stalled and is 9'h000 in IDLE.
- In DATA: rdReady = !txFull and txWriteEnable = rdValid & !txFull. rdData passes to txDataIn in the same cycle. The CRC and counter update on transfer.
- replyStart in cycle N: busy=1 and the first char is available in cycle N+1. With txFull low the packet streams at 1 char/clk with no gap cycles.
- The EOP/EEP write in cycle M gives replyDone=1 and busy=0 in cycle M+1. A new replyStart is accepted in M+1.
- rst mid-packet: at the next edge, state returns to IDLE, all outputs go to reset values, and no EOP/EEP is emitted.

## Test plan
- **Write reply, no address:** replyInstr=0x7C, InitLA=TargLA=0xFE, TID=0x4567, status 0 → FE 01 3C 00 FE 45 67 <CRC = model over those 7 bytes> 100, then replyDone=1 for 1 cycle.
- **Reply address stripping:** replyInstr=0x7D, replyAddr bytes 00 00 12 34 → stream begins 12 34 FE 01 3D…. Header CRC is unchanged from the same header without address.
- **Read reply, 1 byte:** replyInstr=0x4C, Len=1, status 0, rdData=0x01 → FE 01 0C 00 FE TID 00 00 00 01 <hcrc> 01 91 100. The data CRC must be 0x91.
- **Backpressure:** same packets with txFull randomised 50% and rdValid randomised → identical char sequence; txWriteEnable&txFull never 1.
- **Abort:** Len=4, rdError raised after 2 accepted bytes → 2 data chars, then 101, with no data CRC; replyDone pulses and busy=0.
- **Reset mid-header:** rst during the HDR state → txWriteEnable=0 and busy=0 after the edge. The next replyStart yields a complete, correct packet.

Source files
------------

// File: rtl/rmap_reply_tx.sv
// RMAP reply transmitter: serialises reply address, header, header CRC and
// optional read data with data CRC into the 9-bit SpaceWire TX FIFO.
module rmap_reply_tx #(
    parameter int REPLY_ADDR_BYTES = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          replyStart,
    input  logic [7:0]                    replyInstr,
    input  logic [7:0]                    replyStatus,
    input  logic [7:0]                    replyInitLA,
    input  logic [7:0]                    replyTargLA,
    input  logic [15:0]                   replyTransID,
    input  logic [23:0]                   replyDataLen,
    input  logic [8*REPLY_ADDR_BYTES-1:0] replyAddr,
    output logic                          busy,
    output logic                          replyDone,
    input  logic [7:0]                    rdData,
    input  logic                          rdValid,
    output logic                          rdReady,
    input  logic                          rdError,
    output logic                          txWriteEnable,
    output logic [8:0]                    txDataIn,
    input  logic                          txFull
);

    localparam int AW = 8 * REPLY_ADDR_BYTES;
    localparam int CW = $clog2(REPLY_ADDR_BYTES + 1);

    typedef enum logic [2:0] {IDLE, ADDR, HDR, HCRC, DATA, DCRC, EOP, EEP} stateT;

    stateT         state, stateNext;
    logic [5:0]    instrReg;
    logic [7:0]    statusReg;
    logic [7:0]    initLAReg;
    logic [7:0]    targLAReg;
    logic [15:0]   tidReg;
    logic [23:0]   lenReg;
    logic [AW-1:0] addrReg;
    logic [CW-1:0] addrLeft;
    logic [3:0]    hdrIdx;
    logic [3:0]    hdrLast;
    logic [7:0]    hdrByte;
    logic [7:0]    crc;
    logic [23:0]   dataCnt;
    logic          doneReg;
    logic          pending;
    logic [8:0]    charOut;
    logic [CW-1:0] firstNz;
    logic [CW-1:0] addrLeftNext;
    int            addrCount;

    function automatic logic [7:0] crcNext(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c ^ b;
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 8'hE0) : (r >> 1);
        end
        return r;
    endfunction

    // Locate the first non-zero byte of the used address window so zero
    // padding is skipped without spending cycles on it.
    always_comb begin
        addrCount = 4 * int'(replyInstr[1:0]);
        firstNz   = CW'(REPLY_ADDR_BYTES);
        for (int i = REPLY_ADDR_BYTES - 1; i >= 0; i--) begin
            if (i >= REPLY_ADDR_BYTES - addrCount &&
                replyAddr[8*(REPLY_ADDR_BYTES-1-i) +: 8] != 8'h00) begin
                firstNz = CW'(i);
            end
        end
        addrLeftNext = CW'(REPLY_ADDR_BYTES) - firstNz;
    end

    always_comb begin
        hdrLast = instrReg[5] ? 4'd6 : 4'd10;
        case (hdrIdx)
            4'd0:    hdrByte = initLAReg;
            4'd1:    hdrByte = 8'h01;
            4'd2:    hdrByte = {2'b00, instrReg};
            4'd3:    hdrByte = statusReg;
            4'd4:    hdrByte = targLAReg;
            4'd5:    hdrByte = tidReg[15:8];
            4'd6:    hdrByte = tidReg[7:0];
            4'd8:    hdrByte = lenReg[23:16];
            4'd9:    hdrByte = lenReg[15:8];
            4'd10:   hdrByte = lenReg[7:0];
            default: hdrByte = 8'h00;
        endcase
    end

    always_comb begin
        stateNext     = state;
        pending       = 1'b0;
        charOut       = 9'h000;
        rdReady       = 1'b0;
        case (state)
            IDLE: begin
                if (replyStart) begin
                    stateNext = (addrLeftNext != '0) ? ADDR : HDR;
                end
            end
            ADDR: begin
                pending = 1'b1;
                charOut = {1'b0, addrReg[AW-1 -: 8]};
                if (!txFull && addrLeft == CW'(1)) stateNext = HDR;
            end
            HDR: begin
                pending = 1'b1;
                charOut = {1'b0, hdrByte};
                if (!txFull && hdrIdx == hdrLast) stateNext = HCRC;
            end
            HCRC: begin
                pending = 1'b1;
                charOut = {1'b0, crc};
                if (!txFull) begin
                    if (instrReg[5])         stateNext = EOP;
                    else if (lenReg == '0)   stateNext = DCRC;
                    else                     stateNext = DATA;
                end
            end
            // An abort wins over a byte offered in the same cycle.
            DATA: begin
                rdReady = !txFull && !rdError;
                pending = rdValid && !rdError;
                charOut = {1'b0, rdData};
                if (rdError) begin
                    stateNext = EEP;
                end else if (rdValid && !txFull && dataCnt == 24'd1) begin
                    stateNext = DCRC;
                end
            end
            DCRC: begin
                pending = 1'b1;
                charOut = {1'b0, crc};
                if (!txFull) stateNext = EOP;
            end
            EOP: begin
                pending = 1'b1;
                charOut = 9'h100;
                if (!txFull) stateNext = IDLE;
            end
            EEP: begin
                pending = 1'b1;
                charOut = 9'h101;
                if (!txFull) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        txWriteEnable = pending && !txFull;
        txDataIn      = charOut;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            instrReg  <= '0;
            statusReg <= '0;
            initLAReg <= '0;
            targLAReg <= '0;
            tidReg    <= '0;
            lenReg    <= '0;
            addrReg   <= '0;
            addrLeft  <= '0;
            hdrIdx    <= '0;
            crc       <= '0;
            dataCnt   <= '0;
            doneReg   <= 1'b0;
        end else begin
            state   <= stateNext;
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (replyStart) begin
                        instrReg  <= replyInstr[5:0];
                        statusReg <= replyStatus;
                        initLAReg <= replyInitLA;
                        targLAReg <= replyTargLA;
                        tidReg    <= replyTransID;
                        // A failed read carries no data, so its length is sent as zero.
                        lenReg    <= (!replyInstr[5] && replyStatus != 8'h00) ? 24'd0 : replyDataLen;
                        addrReg   <= replyAddr << (8 * firstNz);
                        addrLeft  <= addrLeftNext;
                        hdrIdx    <= '0;
                        crc       <= '0;
                    end
                end
                ADDR: begin
                    if (!txFull) begin
                        addrReg  <= addrReg << 8;
                        addrLeft <= addrLeft - CW'(1);
                    end
                end
                HDR: begin
                    if (!txFull) begin
                        crc    <= crcNext(crc, hdrByte);
                        hdrIdx <= hdrIdx + 4'd1;
                    end
                end
                HCRC: begin
                    if (!txFull) begin
                        crc     <= '0;
                        dataCnt <= lenReg;
                    end
                end
                DATA: begin
                    if (rdValid && rdReady) begin
                        crc     <= crcNext(crc, rdData);
                        dataCnt <= dataCnt - 24'd1;
                    end
                end
                EOP, EEP: begin
                    if (!txFull) doneReg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign replyDone = doneReg;

endmodule
